// File: rtl/csa_word_seq_arb.sv
// Time-shares one external 16-bit adder between two requesters. Each operand is
// added one 16-bit slice per cycle, LSB slice first, with the carry held in a flop.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept one operand pair
// RUN   | one slice per cycle through the external adder
// DONE  | result presented on res_*, waiting for res_ready
module csa_word_seq_arb #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [16*WORDS-1:0]   req0_a,
  input  logic [16*WORDS-1:0]   req0_b,
  input  logic                  req0_cin,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [16*WORDS-1:0]   req1_a,
  input  logic [16*WORDS-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [15:0]           add_sum,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [16*WORDS-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_id,
  output logic                  busy
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            id_q, id_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    id_d       = id_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        // ready is held low while rst is asserted so no requester sees a
        // handshake that the flops are about to ignore
        if (req0_valid && (!req1_valid || !ptr_q)) begin
          req0_ready = !rst;
          a_d        = req0_a;
          b_d        = req0_b;
          cin_d      = req0_cin;
          id_d       = 1'b0;
          ptr_d      = 1'b1;
          idx_d      = '0;
          state_d    = RUN;
        end else if (req1_valid) begin
          req1_ready = !rst;
          a_d        = req1_a;
          b_d        = req1_b;
          cin_d      = req1_cin;
          id_d       = 1'b1;
          ptr_d      = 1'b0;
          idx_d      = '0;
          state_d    = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) begin
            add_a               = a_q[i*16 +: 16];
            add_b               = b_q[i*16 +: 16];
            sum_d[i*16 +: 16]   = add_sum;
          end
        end
        add_cin = (idx_q == '0) ? cin_q : carry_q;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
  assign res_id   = id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_csa_word_seq_arb.sv
// Bench for csa_word_seq_arb: WORDS=4 and WORDS=1 instances, each with a
// behavioural 16-bit adder on add_*, scoreboard-checked results.
module tb_csa_word_seq_arb;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WORDS=4 instance
  logic        r0v4, r0r4, r0c4, r1v4, r1r4, r1c4;
  logic [63:0] r0a4, r0b4, r1a4, r1b4;
  logic [15:0] aa4, ab4, as4;
  logic        ac4, aco4;
  logic        rv4, rr4, rco4, rid4, busy4;
  logic [63:0] rs4;

  // WORDS=1 instance
  logic        r0v1, r0r1, r0c1, r1v1, r1r1, r1c1;
  logic [15:0] r0a1, r0b1, r1a1, r1b1;
  logic [15:0] aa1, ab1, as1;
  logic        ac1, aco1;
  logic        rv1, rr1, rco1, rid1, busy1;
  logic [15:0] rs1;

  assign {aco4, as4} = {1'b0, aa4} + {1'b0, ab4} + {16'b0, ac4};
  assign {aco1, as1} = {1'b0, aa1} + {1'b0, ab1} + {16'b0, ac1};

  csa_word_seq_arb #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v4), .req0_ready(r0r4), .req0_a(r0a4), .req0_b(r0b4), .req0_cin(r0c4),
    .req1_valid(r1v4), .req1_ready(r1r4), .req1_a(r1a4), .req1_b(r1b4), .req1_cin(r1c4),
    .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_sum(as4), .add_cout(aco4),
    .res_valid(rv4), .res_ready(rr4), .res_sum(rs4), .res_cout(rco4), .res_id(rid4),
    .busy(busy4)
  );

  csa_word_seq_arb #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v1), .req0_ready(r0r1), .req0_a(r0a1), .req0_b(r0b1), .req0_cin(r0c1),
    .req1_valid(r1v1), .req1_ready(r1r1), .req1_a(r1a1), .req1_b(r1b1), .req1_cin(r1c1),
    .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1),
    .res_valid(rv1), .res_ready(rr1), .res_sum(rs1), .res_cout(rco1), .res_id(rid1),
    .busy(busy1)
  );

  // scoreboard entries are {id, cout, sum}
  logic [65:0] q4[$];
  logic [17:0] q1[$];
  logic [65:0] e4;
  logic [17:0] e1;
  logic acc4_0, acc4_1, acc1_0, acc1_1;
  int   n_acc4 = 0;
  int   n_acc1 = 0;

  always @(negedge clk) begin
    acc4_0 = 1'b0; acc4_1 = 1'b0; acc1_0 = 1'b0; acc1_1 = 1'b0;
    if (rst === 1'b0) begin
      if (r0v4 && r0r4) begin
        acc4_0 = 1'b1; n_acc4++;
        q4.push_back({1'b0, {1'b0, r0a4} + {1'b0, r0b4} + {64'b0, r0c4}});
      end
      if (r1v4 && r1r4) begin
        acc4_1 = 1'b1; n_acc4++;
        q4.push_back({1'b1, {1'b0, r1a4} + {1'b0, r1b4} + {64'b0, r1c4}});
      end
      if (r0v1 && r0r1) begin
        acc1_0 = 1'b1; n_acc1++;
        q1.push_back({1'b0, {1'b0, r0a1} + {1'b0, r0b1} + {16'b0, r0c1}});
      end
      if (r1v1 && r1r1) begin
        acc1_1 = 1'b1; n_acc1++;
        q1.push_back({1'b1, {1'b0, r1a1} + {1'b0, r1b1} + {16'b0, r1c1}});
      end
      if (rv4 && rr4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: got id=%0d sum=%h, required no result", rid4, rs4);
        end else begin
          e4 = q4.pop_front();
          if ({rid4, rco4, rs4} !== e4) begin
            errors++;
            $display("FAIL sb4_result: got id=%0d cout=%0d sum=%h, required id=%0d cout=%0d sum=%h",
                     rid4, rco4, rs4, e4[65], e4[64], e4[63:0]);
          end
        end
      end
      if (rv1 && rr1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected: got id=%0d sum=%h, required no result", rid1, rs1);
        end else begin
          e1 = q1.pop_front();
          if ({rid1, rco1, rs1} !== e1) begin
            errors++;
            $display("FAIL sb1_result: got id=%0d cout=%0d sum=%h, required id=%0d cout=%0d sum=%h",
                     rid1, rco1, rs1, e1[17], e1[16], e1[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0v4 = 0; r0c4 = 0; r0a4 = '0; r0b4 = '0;
    r1v4 = 0; r1c4 = 0; r1a4 = '0; r1b4 = '0;
    r0v1 = 0; r0c1 = 0; r0a1 = '0; r0b1 = '0;
    r1v1 = 0; r1c1 = 0; r1a1 = '0; r1b1 = '0;
    rr4 = 1; rr1 = 1;
  endtask

  task automatic wait_idle4(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy4 !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    checks++;
    if (busy4 !== 1'b0) begin
      errors++;
      $display("FAIL drain4: busy=%0d after %0d cycles, required 0", busy4, lim);
    end
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL sb4_leftover: %0d results outstanding, required 0", q4.size());
    end
  endtask

  task automatic wait_idle1(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy1 !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    checks++;
    if (busy1 !== 1'b0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain1: busy=%0d outstanding=%0d, required 0 and 0", busy1, q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    r0v4 = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({busy4, rv4, rco4, rid4, ac4, r0r4, r1r4} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl4: got busy,valid,cout,id,cin,rdy0,rdy1=%b, required 0000000",
               {busy4, rv4, rco4, rid4, ac4, r0r4, r1r4});
    end
    checks++;
    if ({rs4, aa4, ab4} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data4: got sum=%h add_a=%h add_b=%h, required all 0", rs4, aa4, ab4);
    end
    checks++;
    if ({busy1, rv1, rs1, rco1, rid1, aa1, ab1, ac1} !== 53'b0) begin
      errors++;
      $display("FAIL reset_dut1: got busy=%0d valid=%0d sum=%h, required 0 0 0", busy1, rv1, rs1);
    end
    tick();
    r0v4 = 0;
    rst  = 0;
  endtask

  task automatic test_carry_ripple();
    int acc, n;
    tick();
    r0a4 = 64'h0000_FFFF_FFFF_FFFF; r0b4 = 64'h1; r0c4 = 0; r0v4 = 1;
    @(negedge clk);
    checks++;
    if (r0r4 !== 1'b1) begin
      errors++;
      $display("FAIL ripple_ready: got req0_ready=%0d, required 1", r0r4);
    end
    acc = cyc + 1;
    tick();
    r0v4 = 0;
    n = 0;
    @(negedge clk);
    while (rv4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rv4 !== 1'b1 || cyc - acc != 4) begin
      errors++;
      $display("FAIL ripple_latency: got valid=%0d after %0d edges, required 1 after 4", rv4, cyc - acc);
    end
    checks++;
    if (rs4 !== 64'h0001_0000_0000_0000 || rco4 !== 1'b0 || rid4 !== 1'b0) begin
      errors++;
      $display("FAIL ripple_result: got sum=%h cout=%0d id=%0d, required 0001000000000000 0 0",
               rs4, rco4, rid4);
    end
    wait_idle4(20);
  endtask

  task automatic test_overflow();
    int n;
    tick();
    r1a4 = 64'hFFFF_FFFF_FFFF_FFFF; r1b4 = 64'h0; r1c4 = 1; r1v4 = 1;
    @(negedge clk);
    checks++;
    if (r1r4 !== 1'b1 || r0r4 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready: got rdy0=%0d rdy1=%0d, required 0 1", r0r4, r1r4);
    end
    tick();
    r1v4 = 0;
    n = 0;
    @(negedge clk);
    while (rv4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rv4 !== 1'b1 || rs4 !== 64'h0 || rco4 !== 1'b1 || rid4 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_result: got valid=%0d sum=%h cout=%0d id=%0d, required 1 0 1 1",
               rv4, rs4, rco4, rid4);
    end
    wait_idle4(20);
  endtask

  task automatic test_round_robin();
    int g[4];
    int t[4];
    int ng = 0;
    int n = 0;
    int gid;
    rst = 1;
    tick();
    tick();
    rst = 0;
    r0a4 = {$urandom, $urandom}; r0b4 = {$urandom, $urandom}; r0c4 = 1; r0v4 = 1;
    r1a4 = {$urandom, $urandom}; r1b4 = {$urandom, $urandom}; r1c4 = 0; r1v4 = 1;
    while (ng < 4 && n < 80) begin
      @(negedge clk);
      gid = r0r4 ? 0 : (r1r4 ? 1 : -1);
      if (gid >= 0) begin g[ng] = gid; t[ng] = cyc; ng++; end
      tick();
      if (gid == 0) begin r0a4 = {$urandom, $urandom}; r0b4 = {$urandom, $urandom}; r0c4 = ~r0c4; end
      if (gid == 1) begin r1a4 = {$urandom, $urandom}; r1b4 = {$urandom, $urandom}; r1c4 = ~r1c4; end
      n++;
    end
    r0v4 = 0;
    r1v4 = 0;
    checks++;
    if (ng != 4) begin
      errors++;
      $display("FAIL rr_grants: got %0d grants, required 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] != i % 2) begin
          errors++;
          $display("FAIL rr_order: grant %0d went to %0d, required %0d", i, g[i], i % 2);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (t[i+1] - t[i] != 6) begin
          errors++;
          $display("FAIL rr_spacing: grants %0d->%0d spaced %0d, required 6", i, i + 1, t[i+1] - t[i]);
        end
      end
    end
    wait_idle4(30);
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [63:0] s;
    logic        id, co;
    tick();
    rr4 = 0;
    r0a4 = 64'h1234_5678_9ABC_DEF0; r0b4 = 64'h0FED_CBA9_8765_4321; r0c4 = 1; r0v4 = 1;
    tick();
    r0v4 = 0;
    @(negedge clk);
    while (rv4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    s = rs4; id = rid4; co = rco4;
    checks++;
    if (rv4 !== 1'b1 || s !== 64'h2222_2222_2222_2212 || id !== 1'b0 || co !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: got valid=%0d sum=%h id=%0d cout=%0d, required 1 2222222222222212 0 0",
               rv4, s, id, co);
    end
    tick();
    r1a4 = {$urandom, $urandom}; r1b4 = {$urandom, $urandom}; r1c4 = 1; r1v4 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rv4 !== 1'b1 || rs4 !== s || rid4 !== id || rco4 !== co || r1r4 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got valid=%0d sum=%h id=%0d rdy1=%0d, required 1 %h %0d 0",
                 i, rv4, rs4, rid4, r1r4, s, id);
      end
    end
    tick();
    rr4 = 1;
    @(negedge clk);
    checks++;
    if (rv4 !== 1'b1 || r1r4 !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: got valid=%0d rdy1=%0d, required 1 0", rv4, r1r4);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rv4 !== 1'b0 || busy4 !== 1'b0 || r1r4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_rearb: got valid=%0d busy=%0d rdy1=%0d, required 0 0 1", rv4, busy4, r1r4);
    end
    tick();
    r1v4 = 0;
    wait_idle4(30);
  endtask

  task automatic test_reset_mid_run();
    tick();
    r0a4 = 64'h1111_2222_3333_4444; r0b4 = 64'h5555_6666_7777_8888; r0c4 = 1; r0v4 = 1;
    tick();
    r0v4 = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (aa4 !== 16'h2222 || ab4 !== 16'h6666 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_slice2: got add_a=%h add_b=%h busy=%0d, required 2222 6666 1", aa4, ab4, busy4);
    end
    tick();
    rst = 1;
    tick();
    rst = 0;
    q4.delete();
    r0a4 = {$urandom, $urandom}; r0b4 = {$urandom, $urandom}; r0c4 = 0; r0v4 = 1;
    r1a4 = {$urandom, $urandom}; r1b4 = {$urandom, $urandom}; r1c4 = 1; r1v4 = 1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0 || rv4 !== 1'b0 || {aa4, ab4, ac4} !== 33'b0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%0d valid=%0d add_a=%h add_b=%h cin=%0d, required all 0",
               busy4, rv4, aa4, ab4, ac4);
    end
    checks++;
    if (r0r4 !== 1'b1 || r1r4 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_ptr: got rdy0=%0d rdy1=%0d, required 1 0", r0r4, r1r4);
    end
    tick();
    r0v4 = 0;
    r1v4 = 0;
    wait_idle4(30);
  endtask

  task automatic test_random();
    int base4 = n_acc4;
    int base1 = n_acc1;
    fork
      begin
        int n = 0;
        while (n_acc4 - base4 < 500 && n < 20000) begin
          tick();
          if (!(r0v4 && !acc4_0)) begin
            r0v4 = ($urandom_range(0, 2) != 0);
            r0a4 = {$urandom, $urandom};
            r0b4 = ($urandom_range(0, 3) == 0) ? ~r0a4 : {$urandom, $urandom};
            r0c4 = 1'($urandom_range(0, 1));
          end
          if (!(r1v4 && !acc4_1)) begin
            r1v4 = ($urandom_range(0, 2) != 0);
            r1a4 = {$urandom, $urandom};
            r1b4 = ($urandom_range(0, 3) == 0) ? ~r1a4 : {$urandom, $urandom};
            r1c4 = 1'($urandom_range(0, 1));
          end
          rr4 = ($urandom_range(0, 3) != 0);
          n++;
        end
        r0v4 = 0; r1v4 = 0; rr4 = 1;
        wait_idle4(30);
      end
      begin
        int n = 0;
        while (n_acc1 - base1 < 500 && n < 20000) begin
          tick();
          if (!(r0v1 && !acc1_0)) begin
            r0v1 = ($urandom_range(0, 2) != 0);
            r0a1 = 16'($urandom);
            r0b1 = ($urandom_range(0, 3) == 0) ? ~r0a1 : 16'($urandom);
            r0c1 = 1'($urandom_range(0, 1));
          end
          if (!(r1v1 && !acc1_1)) begin
            r1v1 = ($urandom_range(0, 2) != 0);
            r1a1 = 16'($urandom);
            r1b1 = ($urandom_range(0, 3) == 0) ? ~r1a1 : 16'($urandom);
            r1c1 = 1'($urandom_range(0, 1));
          end
          rr1 = ($urandom_range(0, 3) != 0);
          n++;
        end
        r0v1 = 0; r1v1 = 0; rr1 = 1;
        wait_idle1(30);
      end
    join
    checks++;
    if (n_acc4 - base4 < 500 || n_acc1 - base1 < 500) begin
      errors++;
      $display("FAIL rand_count: got %0d / %0d accepts, required 500 / 500", n_acc4 - base4, n_acc1 - base1);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
